// File: rtl/etc_planar_tile_collector.sv
// etc_planar_tile_collector
// Accepts one ETC2 planar block (O/H/V base colors + opaque flag), drives an
// external planar pixel generator through 16 pixel indices, collects the 16
// RGBA results and presents them as one 512-bit tile.
//
// Ports
//   sclk, rsrt                   clock, synchronous active-high reset
//   blk_valid/blk_ready          block handshake; blk_alpha, blk_base0/1/2 payload
//   gen_rtr, gen_pixIdx          pixel request to the generator
//   gen_alpha, gen_base0/1/2     block parameters held for the generator
//   gen_rts, gen_r/g/b/a         generator result (1-cycle registered latency)
//   tile_valid/tile_ready        tile handshake; tile_data pixel p at [32p+31:32p] = {a,b,g,r}
//
// Build option
//   ETC_BLK_PREFETCH_EN          adds a one-entry block prefetch register so the
//                                next block can be accepted while a tile is built.
module etc_planar_tile_collector (
  input  logic         sclk,
  input  logic         rsrt,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_alpha,
  input  logic [23:0]  blk_base0,
  input  logic [23:0]  blk_base1,
  input  logic [23:0]  blk_base2,
  output logic         gen_rtr,
  output logic [3:0]   gen_pixIdx,
  output logic         gen_alpha,
  output logic [23:0]  gen_base0,
  output logic [23:0]  gen_base1,
  output logic [23:0]  gen_base2,
  input  logic         gen_rts,
  input  logic [7:0]   gen_r,
  input  logic [7:0]   gen_g,
  input  logic [7:0]   gen_b,
  input  logic [7:0]   gen_a,
  output logic         tile_valid,
  input  logic         tile_ready,
  output logic [511:0] tile_data
);

  localparam int unsigned NPIX  = 16;
  localparam int unsigned PIXW  = 32;
  localparam int unsigned CW    = 24;
  localparam int unsigned TILEW = NPIX * PIXW;
  localparam int unsigned CNTW  = 5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_blk_ready, r_tile_valid, r_gen_rtr, r_gen_alpha;
  logic [3:0]        r_pix_idx;
  logic [CW-1:0]     r_gen_base0, r_gen_base1, r_gen_base2;
  logic [CNTW-1:0]   r_iss_cnt, r_cap_cnt;
  logic [TILEW-1:0]  r_tile_data;

  logic w_blk_acc, w_tile_hs, w_cap, w_cap_last;
  logic w_load_blk, w_start, w_blk_ready_nxt, w_tile_valid_nxt;

`ifdef ETC_BLK_PREFETCH_EN
  logic          r_pf_valid, r_pf_alpha;
  logic [CW-1:0] r_pf_base0, r_pf_base1, r_pf_base2;
  logic          w_load_pf, w_pf_push;
`endif

  assign w_blk_acc  = blk_valid && r_blk_ready;
  assign w_tile_hs  = r_tile_valid && tile_ready;
  // Results are only taken while collecting and the tile is not yet full.
  assign w_cap      = gen_rts && (r_state == S_ISSUE) && !r_cap_cnt[CNTW-1];
  assign w_cap_last = w_cap && (r_cap_cnt == CNTW'(NPIX - 1));

  // State register
  always_ff @(posedge sclk) begin
    if (rsrt) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef ETC_BLK_PREFETCH_EN
        if (r_pf_valid || w_blk_acc) w_state_nxt = S_ISSUE;
`else
        if (w_blk_acc) w_state_nxt = S_ISSUE;
`endif
      end
      // Leave as the 16th pixel is written so tile_valid follows immediately.
      S_ISSUE: if (w_cap_last) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_tile_hs) begin
`ifdef ETC_BLK_PREFETCH_EN
          w_state_nxt = r_pf_valid ? S_ISSUE : S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode (next values of the registered outputs)
  always_comb begin
    w_load_blk       = 1'b0;
    w_start          = 1'b0;
    w_blk_ready_nxt  = 1'b0;
    w_tile_valid_nxt = (w_state_nxt == S_DONE);
`ifdef ETC_BLK_PREFETCH_EN
    w_load_blk      = (r_state == S_IDLE) && !r_pf_valid && w_blk_acc;
    w_load_pf       = r_pf_valid && ((r_state == S_IDLE) || ((r_state == S_DONE) && w_tile_hs));
    w_pf_push       = w_blk_acc && (r_state != S_IDLE);
    w_start         = w_load_blk || w_load_pf;
    w_blk_ready_nxt = !(w_pf_push || (r_pf_valid && !w_load_pf));
`else
    w_load_blk      = (r_state == S_IDLE) && w_blk_acc;
    w_start         = w_load_blk;
    w_blk_ready_nxt = (w_state_nxt == S_IDLE);
`endif
  end

  // Datapath: generator parameters, issue sequencing, pixel capture
  always_ff @(posedge sclk) begin
    if (rsrt) begin
      r_blk_ready  <= 1'b0;
      r_tile_valid <= 1'b0;
      r_gen_rtr    <= 1'b0;
      r_pix_idx    <= '0;
      r_gen_alpha  <= 1'b0;
      r_gen_base0  <= '0;
      r_gen_base1  <= '0;
      r_gen_base2  <= '0;
      r_iss_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_tile_data  <= '0;
`ifdef ETC_BLK_PREFETCH_EN
      r_pf_valid   <= 1'b0;
      r_pf_alpha   <= 1'b0;
      r_pf_base0   <= '0;
      r_pf_base1   <= '0;
      r_pf_base2   <= '0;
`endif
    end else begin
      r_blk_ready  <= w_blk_ready_nxt;
      r_tile_valid <= w_tile_valid_nxt;

      if (w_start) begin
`ifdef ETC_BLK_PREFETCH_EN
        r_gen_alpha <= w_load_pf ? r_pf_alpha : blk_alpha;
        r_gen_base0 <= w_load_pf ? r_pf_base0 : blk_base0;
        r_gen_base1 <= w_load_pf ? r_pf_base1 : blk_base1;
        r_gen_base2 <= w_load_pf ? r_pf_base2 : blk_base2;
`else
        r_gen_alpha <= blk_alpha;
        r_gen_base0 <= blk_base0;
        r_gen_base1 <= blk_base1;
        r_gen_base2 <= blk_base2;
`endif
        r_gen_rtr <= 1'b1;
        r_pix_idx <= '0;
        r_iss_cnt <= '0;
        r_cap_cnt <= '0;
      end else if ((r_state == S_ISSUE) && r_gen_rtr) begin
        // 16 issue cycles plus one drain cycle holding index 15.
        if (r_iss_cnt < CNTW'(NPIX)) begin
          r_iss_cnt <= r_iss_cnt + CNTW'(1);
          if (r_pix_idx != 4'(NPIX - 1)) r_pix_idx <= r_pix_idx + 4'd1;
        end else begin
          r_gen_rtr <= 1'b0;
        end
      end else if (w_tile_hs) begin
        r_iss_cnt <= '0;
        r_cap_cnt <= '0;
        r_pix_idx <= '0;
      end

      if (w_cap) begin
        r_tile_data[{r_cap_cnt[3:0], 5'd0} +: PIXW] <= {gen_a, gen_b, gen_g, gen_r};
        r_cap_cnt <= r_cap_cnt + CNTW'(1);
      end

`ifdef ETC_BLK_PREFETCH_EN
      if (w_pf_push) begin
        r_pf_valid <= 1'b1;
        r_pf_alpha <= blk_alpha;
        r_pf_base0 <= blk_base0;
        r_pf_base1 <= blk_base1;
        r_pf_base2 <= blk_base2;
      end else if (w_load_pf) begin
        r_pf_valid <= 1'b0;
      end
`endif
    end
  end

  assign blk_ready  = r_blk_ready;
  assign gen_rtr    = r_gen_rtr;
  assign gen_pixIdx = r_pix_idx;
  assign gen_alpha  = r_gen_alpha;
  assign gen_base0  = r_gen_base0;
  assign gen_base1  = r_gen_base1;
  assign gen_base2  = r_gen_base2;
  assign tile_valid = r_tile_valid;
  assign tile_data  = r_tile_data;

endmodule

// File: tb/tb_etc_planar_tile_collector.sv
// Bench for etc_planar_tile_collector: models the planar pixel generator,
// queues expected tiles when blocks are accepted and compares them in a
// negedge monitor as tiles are handed off.
module tb_etc_planar_tile_collector;

  logic         sclk = 1'b0;
  logic         rsrt, blk_valid, blk_ready, blk_alpha;
  logic [23:0]  blk_base0, blk_base1, blk_base2;
  logic         gen_rtr, gen_alpha;
  logic [3:0]   gen_pixIdx;
  logic [23:0]  gen_base0, gen_base1, gen_base2;
  logic         gen_rts;
  logic [7:0]   gen_r, gen_g, gen_b, gen_a;
  logic         tile_valid, tile_ready;
  logic [511:0] tile_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [511:0] data;
    int           exp_cyc;
  } exp_t;
  exp_t sb[$];

  etc_planar_tile_collector dut (
    .sclk(sclk), .rsrt(rsrt),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_alpha(blk_alpha),
    .blk_base0(blk_base0), .blk_base1(blk_base1), .blk_base2(blk_base2),
    .gen_rtr(gen_rtr), .gen_pixIdx(gen_pixIdx), .gen_alpha(gen_alpha),
    .gen_base0(gen_base0), .gen_base1(gen_base1), .gen_base2(gen_base2),
    .gen_rts(gen_rts), .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b), .gen_a(gen_a),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ETC2 planar channel: (x*(H-O) + y*(V-O) + 4*O + 2) >> 2, clamped to 0..255
  function automatic logic [7:0] pl_ch(input int o, input int h, input int v,
                                       input int x, input int y);
    int t;
    t = (x * (h - o) + y * (v - o) + 4 * o + 2) >>> 2;
    if (t < 0) t = 0;
    else if (t > 255) t = 255;
    return 8'(t);
  endfunction

  function automatic logic [31:0] model_pix(input logic al, input logic [23:0] b0,
                                            input logic [23:0] b1, input logic [23:0] b2,
                                            input logic [3:0] idx);
    int x, y;
    logic [7:0] r, g, b;
    x = int'(idx[3:2]);
    y = int'(idx[1:0]);
    r = pl_ch(int'(b0[7:0]),   int'(b1[7:0]),   int'(b2[7:0]),   x, y);
    g = pl_ch(int'(b0[15:8]),  int'(b1[15:8]),  int'(b2[15:8]),  x, y);
    b = pl_ch(int'(b0[23:16]), int'(b1[23:16]), int'(b2[23:16]), x, y);
    return {al ? 8'hFF : 8'h00, b, g, r};
  endfunction

  function automatic logic [511:0] model_tile(input logic al, input logic [23:0] b0,
                                              input logic [23:0] b1, input logic [23:0] b2);
    logic [511:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[32*i +: 32] = model_pix(al, b0, b1, b2, 4'(i));
    return t;
  endfunction

  // Planar pixel generator: one-cycle registered latency, answers only requests.
  always @(posedge sclk) begin
    if (rsrt) begin
      gen_rts <= 1'b0;
      {gen_a, gen_b, gen_g, gen_r} <= 32'h0;
    end else begin
      gen_rts <= gen_rtr;
      if (gen_rtr)
        {gen_a, gen_b, gen_g, gen_r} <= model_pix(gen_alpha, gen_base0, gen_base1,
                                                  gen_base2, gen_pixIdx);
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: issue-index sequence, tile latency, request count, tile contents.
  int   rtr_cnt = 0;
  logic prev_tv = 1'b0;
  always @(negedge sclk) begin
    if (rsrt) begin
      rtr_cnt = 0;
      prev_tv = 1'b0;
    end else begin
      if (gen_rtr) begin
        chk("pix_idx", 512'(gen_pixIdx), 512'((rtr_cnt > 15) ? 15 : rtr_cnt));
        rtr_cnt++;
      end
      if (tile_valid && !prev_tv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tile cyc=%0d got=tile_valid want=none", cyc);
        end else begin
          chk("tile_latency", 512'(cyc), 512'(sb[0].exp_cyc));
          chk("rtr_cycles", 512'(rtr_cnt), 512'(17));
        end
        rtr_cnt = 0;
      end
      if (tile_valid && tile_ready && sb.size() > 0) begin
        chk("tile_data", tile_data, sb[0].data);
        void'(sb.pop_front());
      end
      prev_tv = tile_valid && !tile_ready;
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_block(input logic al, input logic [23:0] b0, input logic [23:0] b1,
                            input logic [23:0] b2, output int acc);
    int n;
    blk_valid = 1'b1;
    blk_alpha = al;
    blk_base0 = b0;
    blk_base1 = b1;
    blk_base2 = b2;
    n = 0;
    while (!blk_ready && n < 100) begin
      tick();
      n++;
    end
    chk("blk_accept", 512'(blk_ready), 512'(1));
    acc = cyc;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic push_exp(input logic al, input logic [23:0] b0, input logic [23:0] b1,
                          input logic [23:0] b2, input int ec);
    exp_t e;
    e.data    = model_tile(al, b0, b1, b2);
    e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic wait_tile();
    int n;
    n = 0;
    while (!tile_valid && n < 60) begin
      tick();
      n++;
    end
    chk("tile_wait", 512'(tile_valid), 512'(1));
  endtask

  localparam logic [23:0] A0 = 24'h302010;
  localparam logic [23:0] A1 = 24'h705050;
  localparam logic [23:0] A2 = 24'h302010;

  initial begin
    int acc, acc2, n;
    logic [511:0] rec;
    logic [7:0] aor;
    rsrt = 1'b1; blk_valid = 1'b0; blk_alpha = 1'b0; tile_ready = 1'b1;
    blk_base0 = '0; blk_base1 = '0; blk_base2 = '0;
    repeat (3) tick();
    chk("rst_gen_rtr",    512'(gen_rtr),    512'(0));
    chk("rst_pixidx",     512'(gen_pixIdx), 512'(0));
    chk("rst_gen_alpha",  512'(gen_alpha),  512'(0));
    chk("rst_gen_bases",  512'({gen_base0, gen_base1, gen_base2}), 512'(0));
    chk("rst_tile_valid", 512'(tile_valid), 512'(0));
    chk("rst_tile_data",  tile_data,        512'(0));
    rsrt = 1'b0;
    tick();
    chk("rst_blk_ready", 512'(blk_ready), 512'(1));

    // Reference block, opaque
    send_block(1'b1, A0, A1, A2, acc);
    push_exp(1'b1, A0, A1, A2, acc + 18);
    wait_tile();
    chk("t1_pix0",     512'(tile_data[31:0]),      512'(32'hFF302010));
    chk("t1_pix12_r",  512'(tile_data[12*32 +: 8]), 512'(8'h40));
    tick();
    chk("t1_pulse", 512'(tile_valid), 512'(0));

    // Same block, transparent
    send_block(1'b0, A0, A1, A2, acc);
    push_exp(1'b0, A0, A1, A2, acc + 18);
    wait_tile();
    chk("t2_pix0", 512'(tile_data[31:0]), 512'(32'h00302010));
    aor = '0;
    for (int i = 0; i < 16; i++) aor = aor | tile_data[32*i+24 +: 8];
    chk("t2_alpha_or", 512'(aor), 512'(0));
    tick();

    // Back-pressure: tile must hold while tile_ready is low
    tile_ready = 1'b0;
    send_block(1'b1, A0, A1, A2, acc);
    push_exp(1'b1, A0, A1, A2, acc + 18);
    wait_tile();
    rec = tile_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_valid", 512'(tile_valid), 512'(1));
      chk("stall_data",  tile_data,        rec);
      chk("stall_rtr",   512'(gen_rtr),    512'(0));
`ifndef ETC_BLK_PREFETCH_EN
      chk("stall_blk_ready", 512'(blk_ready), 512'(0));
`endif
    end
    tile_ready = 1'b1;
    tick();
    chk("release_idle",  512'(blk_ready),  512'(1));
    chk("release_valid", 512'(tile_valid), 512'(0));

    // Reset at issue cycle 8 discards the partial tile
    send_block(1'b1, A0, A1, A2, acc);
    n = 0;
    while (cyc < acc + 9 && n < 40) begin
      tick();
      n++;
    end
    rsrt = 1'b1;
    tick();
    chk("abort_rtr",   512'(gen_rtr),    512'(0));
    chk("abort_data",  tile_data,        512'(0));
    chk("abort_valid", 512'(tile_valid), 512'(0));
    rsrt = 1'b0;
    tick();
    chk("abort_blk_ready", 512'(blk_ready), 512'(1));
    repeat (25) tick();
    send_block(1'b1, A0, A1, A2, acc);
    push_exp(1'b1, A0, A1, A2, acc + 18);
    wait_tile();
    tick();

    // Clamp at both ends of the range
    send_block(1'b1, 24'hFFFFFF, 24'h000000, 24'h000000, acc);
    push_exp(1'b1, 24'hFFFFFF, 24'h000000, 24'h000000, acc + 18);
    wait_tile();
    chk("clamp_pix0",  512'(tile_data[31:0]),    512'(32'hFFFFFFFF));
    chk("clamp_pix15", 512'(tile_data[511:480]), 512'(32'hFF000000));
    tick();

`ifdef ETC_BLK_PREFETCH_EN
    // Back-to-back blocks through the prefetch register
    send_block(1'b1, A0, A1, A2, acc);
    push_exp(1'b1, A0, A1, A2, acc + 18);
    send_block(1'b0, 24'hFFFFFF, 24'h000000, 24'h000000, acc2);
    push_exp(1'b0, 24'hFFFFFF, 24'h000000, 24'h000000, acc + 36);
    chk("pf_second_accept", 512'(acc2), 512'(acc + 1));
`endif

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("sb_drain", 512'(sb.size()), 512'(0));
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etc_planar_tile_collector.md
ETC_PLANAR_TILE_COLLECTOR -- requirements
Module: etc_planar_tile_collector

Interface
REQ-001 SHALL have ports: sclk  in  1  sole clock; all logic on posedge sclk.
REQ-002 SHALL have: rsrt  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: blk_valid  in  1  planar block base colors offered.
REQ-004 SHALL have: blk_ready  out  1  block accepted when blk_valid && blk_ready.
REQ-005 SHALL have: blk_alpha  in  1  opaque flag; blk_base0/blk_base1/blk_base2  in  24 each  O/H/V colors, {B[23:16],G[15:8],R[7:0]}.
REQ-006 SHALL have: gen_rtr  out  1; gen_pixIdx  out  4; gen_alpha  out  1; gen_base0/1/2  out  24 each -- drive the planar pixel generator.
REQ-007 SHALL have: gen_rts  in  1; gen_r/gen_g/gen_b/gen_a  in  8 each -- generator result, valid when gen_rts.
REQ-008 SHALL have: tile_valid  out  1; tile_ready  in  1; tile_data  out  512 -- pixel p at [32p+31:32p] as {a,b,g,r}.

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE.
REQ-010 IDLE: blk_ready=1; on blk_valid, latch alpha and base colors into gen_* registers, next state ISSUE.
REQ-011 ISSUE: gen_rtr=1 for exactly 17 consecutive cycles; gen_pixIdx=0,1,...,15 on cycles 0..15, held at 15 on drain cycle 16.
REQ-012 Generator has 1-cycle registered latency and gen_rts requires gen_rtr high; the drain cycle SHALL keep gen_rtr high to capture pixel 15.
REQ-013 Capture counter (5 bit) SHALL write gen_{a,b,g,r} into slot cap_cnt and increment on each gen_rts in ISSUE; gen_rts outside ISSUE or with cap_cnt=16 SHALL be ignored.
REQ-014 ISSUE SHALL exit to DONE when cap_cnt reaches 16; block accepted at cycle T gives tile_valid at T+18.
REQ-015 DONE: tile_valid=1, tile_data stable until tile_ready; handshake cycle returns to IDLE, cap_cnt and issue counter cleared.
REQ-016 gen_base*/gen_alpha SHALL remain stable throughout ISSUE.
REQ-017 Pixel index mapping SHALL match generator: x=pixIdx[3:2], y=pixIdx[1:0].
REQ-018 gen_rtr SHALL be 0 in IDLE and DONE; no gen_pixIdx issue in those states.

Reset
REQ-019 rsrt SHALL force IDLE, counters 0, gen_rtr=0, gen_pixIdx=0, gen_alpha=0, gen_base*=0, tile_valid=0, tile_data=0; blk_ready=1 cycle after release.
REQ-020 rsrt mid-ISSUE SHALL drop gen_rtr on next cycle, discard partial tile; no tile_valid for aborted block.
REQ-021 rsrt wins over simultaneous blk_valid or tile_ready.

Configuration
REQ-022 Macro ETC_BLK_PREFETCH_EN SHALL select one-entry block prefetch register.
REQ-023 Defined: blk_ready=1 whenever prefetch register empty (any state); on DONE handshake with prefetch full, load gen_* from it and enter ISSUE next cycle (no IDLE cycle); blk_valid coinciding with that handshake while empty is accepted into prefetch.
REQ-024 Undefined: no prefetch register; blk_ready=1 only in IDLE; behaviour per REQ-010..015.

Verification
REQ-025 base0=0x302010, base1=0x705050, base2=0x302010, alpha=1, tile_ready=1 -> tile_valid at T+18; pixel0 r=0x10 g=0x20 b=0x30 a=0xFF; pixel12 r=0x40; one-cycle pulse.
REQ-026 Same block, alpha=0 -> all 16 a bytes 0x00, rgb unchanged.
REQ-027 Hold tile_ready=0 for 20 cycles -> tile_valid and tile_data constant, gen_rtr=0, blk_ready=0 (prefetch off); release -> IDLE next cycle.
REQ-028 Assert rsrt at ISSUE cycle 8 -> gen_rtr=0 next cycle, tile_data=0, no tile_valid; new block afterwards produces correct tile.
REQ-029 Base colors forcing clamp (base0=0xFFFFFF, base1=base2=0x000000) -> pixel0 rgb=0xFF, pixel15 rgb=0x00 after clamp.
REQ-030 ETC_BLK_PREFETCH_EN defined, two back-to-back blocks -> second gen_rtr rises cycle after first tile handshake; 36 cycles from first accept to second tile_valid.
